// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU operation codes, forwarding select and default widths.
package cpu_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int REG_AW_DEF = 5;
   localparam int CNT_W_DEF  = 16;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;
   localparam logic [3:0] ALU_XOR = 4'b0011;
   localparam logic [3:0] ALU_MUL = 4'b0100;

   typedef enum logic [1:0] {
      FWD_REG   = 2'd0,
      FWD_MEMWB = 2'd1,
      FWD_EXMEM = 2'd2
   } fwd_sel_e;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding mux: picks the freshest value of one source register.
module fwd_mux
   import cpu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int REG_AW = REG_AW_DEF
) (
   input  logic [REG_AW-1:0] addr,
   input  logic [DATA_W-1:0] reg_data,
   input  logic              exmem_reg_write,
   input  logic [REG_AW-1:0] exmem_rd,
   input  logic [DATA_W-1:0] exmem_result,
   input  logic              memwb_reg_write,
   input  logic [REG_AW-1:0] memwb_rd,
   input  logic [DATA_W-1:0] memwb_data,
   output logic [DATA_W-1:0] data,
   output fwd_sel_e          sel
);

   // EX/MEM is younger than MEM/WB so it wins; register 0 is hard-wired and never forwarded.
   always_comb begin
      sel  = FWD_REG;
      data = reg_data;
      if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == addr)) begin
         sel  = FWD_EXMEM;
         data = exmem_result;
      end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == addr)) begin
         sel  = FWD_MEMWB;
         data = memwb_data;
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use stall and bubble counter.
module id_ex_stage
   import cpu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int REG_AW = REG_AW_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              id_valid_i,
   input  logic [DATA_W-1:0] id_rs_data_i,
   input  logic [DATA_W-1:0] id_rt_data_i,
   input  logic [DATA_W-1:0] id_imm_i,
   input  logic [REG_AW-1:0] id_rs_addr_i,
   input  logic [REG_AW-1:0] id_rt_addr_i,
   input  logic [REG_AW-1:0] id_rd_addr_i,
   input  logic [3:0]        id_alu_ctrl_i,
   input  logic              id_alu_src_i,
   input  logic              id_reg_write_i,
   input  logic              id_mem_read_i,
   input  logic              id_mem_write_i,
   input  logic              id_mem_to_reg_i,
   input  logic              flush_i,
   input  logic              exmem_reg_write_i,
   input  logic [REG_AW-1:0] exmem_rd_i,
   input  logic [DATA_W-1:0] exmem_result_i,
   input  logic              memwb_reg_write_i,
   input  logic [REG_AW-1:0] memwb_rd_i,
   input  logic [DATA_W-1:0] memwb_data_i,
   output logic [DATA_W-1:0] alu_src1_o,
   output logic [DATA_W-1:0] alu_src2_o,
   output logic [3:0]        alu_ctrl_o,
   output logic [DATA_W-1:0] ex_store_data_o,
   output logic [REG_AW-1:0] ex_rd_o,
   output logic              ex_valid_o,
   output logic              ex_reg_write_o,
   output logic              ex_mem_read_o,
   output logic              ex_mem_write_o,
   output logic              ex_mem_to_reg_o,
   output logic              stall_o,
   output logic [CNT_W-1:0]  bubble_cnt_o
);

   logic [DATA_W-1:0] ex_rs_data;
   logic [DATA_W-1:0] ex_rt_data;
   logic [DATA_W-1:0] ex_imm;
   logic [REG_AW-1:0] ex_rs_addr;
   logic [REG_AW-1:0] ex_rt_addr;
   logic              ex_alu_src;
   logic [DATA_W-1:0] rs_fwd_data;
   logic [DATA_W-1:0] rt_fwd_data;
   fwd_sel_e          unused_rs_sel;
   fwd_sel_e          unused_rt_sel;
   logic              load_use;
   logic              rt_needed;
   logic              bubble;
   logic              count_bubble;

   // rt only matters as a source when it feeds the ALU or supplies store data.
   assign rt_needed = ~id_alu_src_i | id_mem_write_i;

   assign load_use = ex_valid_o & ex_mem_read_o & id_valid_i & (ex_rd_o != '0) &
                     ((ex_rd_o == id_rs_addr_i) | ((ex_rd_o == id_rt_addr_i) & rt_needed));

   // A squashed instruction needs no stall, so flush overrides the hazard.
   assign stall_o      = load_use & ~flush_i;
   assign bubble       = flush_i | stall_o;
   assign count_bubble = stall_o | (flush_i & id_valid_i);

   fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
      .addr            (ex_rs_addr),
      .reg_data        (ex_rs_data),
      .exmem_reg_write (exmem_reg_write_i),
      .exmem_rd        (exmem_rd_i),
      .exmem_result    (exmem_result_i),
      .memwb_reg_write (memwb_reg_write_i),
      .memwb_rd        (memwb_rd_i),
      .memwb_data      (memwb_data_i),
      .data            (rs_fwd_data),
      .sel             (unused_rs_sel)
   );

   fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
      .addr            (ex_rt_addr),
      .reg_data        (ex_rt_data),
      .exmem_reg_write (exmem_reg_write_i),
      .exmem_rd        (exmem_rd_i),
      .exmem_result    (exmem_result_i),
      .memwb_reg_write (memwb_reg_write_i),
      .memwb_rd        (memwb_rd_i),
      .memwb_data      (memwb_data_i),
      .data            (rt_fwd_data),
      .sel             (unused_rt_sel)
   );

   assign alu_src1_o      = rs_fwd_data;
   assign ex_store_data_o = rt_fwd_data;
   assign alu_src2_o      = ex_alu_src ? ex_imm : rt_fwd_data;

   // Pipeline register: load ID, or an all-zero bubble on flush/stall; invalid ID loads zeroed control.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ex_valid_o      <= 1'b0;
         ex_rs_data      <= '0;
         ex_rt_data      <= '0;
         ex_imm          <= '0;
         ex_rs_addr      <= '0;
         ex_rt_addr      <= '0;
         ex_rd_o         <= '0;
         alu_ctrl_o      <= 4'b0000;
         ex_alu_src      <= 1'b0;
         ex_reg_write_o  <= 1'b0;
         ex_mem_read_o   <= 1'b0;
         ex_mem_write_o  <= 1'b0;
         ex_mem_to_reg_o <= 1'b0;
      end else if (bubble) begin
         ex_valid_o      <= 1'b0;
         ex_rs_data      <= '0;
         ex_rt_data      <= '0;
         ex_imm          <= '0;
         ex_rs_addr      <= '0;
         ex_rt_addr      <= '0;
         ex_rd_o         <= '0;
         alu_ctrl_o      <= 4'b0000;
         ex_alu_src      <= 1'b0;
         ex_reg_write_o  <= 1'b0;
         ex_mem_read_o   <= 1'b0;
         ex_mem_write_o  <= 1'b0;
         ex_mem_to_reg_o <= 1'b0;
      end else begin
         ex_valid_o      <= id_valid_i;
         ex_rs_data      <= id_rs_data_i;
         ex_rt_data      <= id_rt_data_i;
         ex_imm          <= id_imm_i;
         ex_rs_addr      <= id_rs_addr_i;
         ex_rt_addr      <= id_rt_addr_i;
         ex_rd_o         <= id_rd_addr_i;
         alu_ctrl_o      <= id_valid_i ? id_alu_ctrl_i : 4'b0000;
         ex_alu_src      <= id_valid_i & id_alu_src_i;
         ex_reg_write_o  <= id_valid_i & id_reg_write_i;
         ex_mem_read_o   <= id_valid_i & id_mem_read_i;
         ex_mem_write_o  <= id_valid_i & id_mem_write_i;
         ex_mem_to_reg_o <= id_valid_i & id_mem_to_reg_i;
      end
   end

   // Bubble counter saturates at all-ones so long runs never wrap back to small values.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         bubble_cnt_o <= '0;
      end else if (count_bubble && (bubble_cnt_o != '1)) begin
         bubble_cnt_o <= bubble_cnt_o + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage against a behavioural ID/EX model.
module tb_id_ex_stage;
   import cpu_pkg::*;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int CW = 4;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          id_valid_i;
   logic [DW-1:0] id_rs_data_i, id_rt_data_i, id_imm_i;
   logic [AW-1:0] id_rs_addr_i, id_rt_addr_i, id_rd_addr_i;
   logic [3:0]    id_alu_ctrl_i;
   logic          id_alu_src_i, id_reg_write_i, id_mem_read_i, id_mem_write_i, id_mem_to_reg_i;
   logic          flush_i;
   logic          exmem_reg_write_i;
   logic [AW-1:0] exmem_rd_i;
   logic [DW-1:0] exmem_result_i;
   logic          memwb_reg_write_i;
   logic [AW-1:0] memwb_rd_i;
   logic [DW-1:0] memwb_data_i;
   logic [DW-1:0] alu_src1_o, alu_src2_o, ex_store_data_o;
   logic [3:0]    alu_ctrl_o;
   logic [AW-1:0] ex_rd_o;
   logic          ex_valid_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o;
   logic          stall_o;
   logic [CW-1:0] bubble_cnt_o;

   id_ex_stage #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i),
      .id_rs_data_i(id_rs_data_i), .id_rt_data_i(id_rt_data_i), .id_imm_i(id_imm_i),
      .id_rs_addr_i(id_rs_addr_i), .id_rt_addr_i(id_rt_addr_i), .id_rd_addr_i(id_rd_addr_i),
      .id_alu_ctrl_i(id_alu_ctrl_i), .id_alu_src_i(id_alu_src_i),
      .id_reg_write_i(id_reg_write_i), .id_mem_read_i(id_mem_read_i),
      .id_mem_write_i(id_mem_write_i), .id_mem_to_reg_i(id_mem_to_reg_i),
      .flush_i(flush_i),
      .exmem_reg_write_i(exmem_reg_write_i), .exmem_rd_i(exmem_rd_i), .exmem_result_i(exmem_result_i),
      .memwb_reg_write_i(memwb_reg_write_i), .memwb_rd_i(memwb_rd_i), .memwb_data_i(memwb_data_i),
      .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o), .alu_ctrl_o(alu_ctrl_o),
      .ex_store_data_o(ex_store_data_o), .ex_rd_o(ex_rd_o), .ex_valid_o(ex_valid_o),
      .ex_reg_write_o(ex_reg_write_o), .ex_mem_read_o(ex_mem_read_o),
      .ex_mem_write_o(ex_mem_write_o), .ex_mem_to_reg_o(ex_mem_to_reg_o),
      .stall_o(stall_o), .bubble_cnt_o(bubble_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   // Model of the instruction currently sitting in EX.
   typedef struct packed {
      logic          valid;
      logic [DW-1:0] rs_data, rt_data, imm;
      logic [AW-1:0] rs, rt, rd;
      logic [3:0]    ctrl;
      logic          alu_src, rw, mr, mw, m2r;
   } ex_model_t;

   ex_model_t m;
   int        m_cnt;
   int        pass_cnt = 0;
   int        chk_cnt  = 0;

   // The ID instruction depends on a load in EX whose result is not ready yet.
   function automatic logic model_stall();
      logic uses_rs, uses_rt;
      uses_rs = (id_rs_addr_i == m.rd);
      uses_rt = (id_rt_addr_i == m.rd) && (!id_alu_src_i || id_mem_write_i);
      return m.valid && m.mr && id_valid_i && (m.rd != 0) && (uses_rs || uses_rt) && !flush_i;
   endfunction

   function automatic logic [DW-1:0] model_fwd(input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (exmem_reg_write_i && exmem_rd_i != 0 && exmem_rd_i == a) return exmem_result_i;
      if (memwb_reg_write_i && memwb_rd_i != 0 && memwb_rd_i == a) return memwb_data_i;
      return d;
   endfunction

   function automatic logic [DW-1:0] exp_src1();
      return model_fwd(m.rs, m.rs_data);
   endfunction

   function automatic logic [DW-1:0] exp_store();
      return model_fwd(m.rt, m.rt_data);
   endfunction

   function automatic logic [DW-1:0] exp_src2();
      return m.alu_src ? m.imm : exp_store();
   endfunction

   task automatic idle_inputs();
      id_valid_i = 0; id_rs_data_i = 0; id_rt_data_i = 0; id_imm_i = 0;
      id_rs_addr_i = 0; id_rt_addr_i = 0; id_rd_addr_i = 0; id_alu_ctrl_i = 0;
      id_alu_src_i = 0; id_reg_write_i = 0; id_mem_read_i = 0; id_mem_write_i = 0;
      id_mem_to_reg_i = 0; flush_i = 0;
      exmem_reg_write_i = 0; exmem_rd_i = 0; exmem_result_i = 0;
      memwb_reg_write_i = 0; memwb_rd_i = 0; memwb_data_i = 0;
   endtask

   task automatic drive_instr(input logic [3:0] ctrl, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                              input logic [AW-1:0] rd, input logic [DW-1:0] rsd, input logic [DW-1:0] rtd,
                              input logic asrc, input logic mr);
      id_valid_i = 1; id_alu_ctrl_i = ctrl; id_rs_addr_i = rs; id_rt_addr_i = rt; id_rd_addr_i = rd;
      id_rs_data_i = rsd; id_rt_data_i = rtd; id_imm_i = 32'h0000_0100; id_alu_src_i = asrc;
      id_mem_read_i = mr; id_mem_to_reg_i = mr; id_reg_write_i = 1; id_mem_write_i = 0;
   endtask

   // Advance one clock, updating the model from the inputs presented during this cycle.
   task automatic clock_cycle();
      ex_model_t nxt;
      logic      st;
      st  = model_stall();
      nxt = '0;
      if (flush_i || st) begin
         if (st || id_valid_i) m_cnt = (m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1;
      end else begin
         nxt.valid   = id_valid_i;
         nxt.rs_data = id_rs_data_i; nxt.rt_data = id_rt_data_i; nxt.imm = id_imm_i;
         nxt.rs = id_rs_addr_i; nxt.rt = id_rt_addr_i; nxt.rd = id_rd_addr_i;
         if (id_valid_i) begin
            nxt.ctrl = id_alu_ctrl_i; nxt.alu_src = id_alu_src_i; nxt.rw = id_reg_write_i;
            nxt.mr = id_mem_read_i; nxt.mw = id_mem_write_i; nxt.m2r = id_mem_to_reg_i;
         end
      end
      @(posedge clk_i);
      m = nxt;
      @(negedge clk_i);
   endtask

   task automatic test_reset();
      @(negedge clk_i);
      rst_i = 1;
      drive_instr(ALU_ADD, 5'd1, 5'd2, 5'd3, 32'd5, 32'd6, 1'b0, 1'b0);
      flush_i = 1;
      clock_cycle();
      flush_i = 0;
      clock_cycle();
      chk_cnt++;
      if (ex_valid_o !== 1'b1 || bubble_cnt_o !== 4'd1)
         $display("[TB] FAIL reset_preload: valid=%0b cnt=%0d expected valid=1 cnt=1", ex_valid_o, bubble_cnt_o);
      else pass_cnt++;
      #2 rst_i = 0;
      m = '0; m_cnt = 0;
      #1;
      chk_cnt++;
      if ({ex_valid_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o} !== 5'b0)
         $display("[TB] FAIL reset_ctrl: got %b expected 00000",
                  {ex_valid_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o});
      else pass_cnt++;
      chk_cnt++;
      if (alu_ctrl_o !== 4'b0 || ex_rd_o !== '0 || bubble_cnt_o !== '0)
         $display("[TB] FAIL reset_regs: ctrl=%b rd=%0d cnt=%0d expected 0", alu_ctrl_o, ex_rd_o, bubble_cnt_o);
      else pass_cnt++;
      chk_cnt++;
      if (alu_src1_o !== exp_src1() || alu_src2_o !== exp_src2())
         $display("[TB] FAIL reset_operands: src1=%h src2=%h expected %h %h", alu_src1_o, alu_src2_o, exp_src1(), exp_src2());
      else pass_cnt++;
      @(negedge clk_i);
      rst_i = 1;
      idle_inputs();
   endtask

   task automatic test_pass_through();
      drive_instr(ALU_ADD, 5'd5, 5'd7, 5'd10, 32'd3, 32'd4, 1'b0, 1'b0);
      clock_cycle();
      chk_cnt++;
      if (alu_src1_o !== 32'd3 || alu_src2_o !== 32'd4 || alu_ctrl_o !== ALU_ADD)
         $display("[TB] FAIL pass_through: src1=%0d src2=%0d ctrl=%b expected 3 4 0010", alu_src1_o, alu_src2_o, alu_ctrl_o);
      else pass_cnt++;
      chk_cnt++;
      if (ex_valid_o !== 1'b1 || ex_rd_o !== 5'd10 || ex_reg_write_o !== 1'b1)
         $display("[TB] FAIL pass_ctrl: valid=%0b rd=%0d rw=%0b expected 1 10 1", ex_valid_o, ex_rd_o, ex_reg_write_o);
      else pass_cnt++;
      idle_inputs();
   endtask

   task automatic test_forwarding();
      drive_instr(ALU_SUB, 5'd8, 5'd0, 5'd4, 32'h33, 32'h0, 1'b0, 1'b0);
      clock_cycle();
      idle_inputs();
      exmem_reg_write_i = 1; exmem_rd_i = 5'd8; exmem_result_i = 32'h11;
      memwb_reg_write_i = 1; memwb_rd_i = 5'd8; memwb_data_i = 32'h22;
      #1;
      chk_cnt++;
      if (alu_src1_o !== 32'h11 || alu_src1_o !== exp_src1())
         $display("[TB] FAIL fwd_exmem_priority: got %h expected 11", alu_src1_o);
      else pass_cnt++;
      exmem_reg_write_i = 0;
      #1;
      chk_cnt++;
      if (alu_src1_o !== 32'h22 || alu_src1_o !== exp_src1())
         $display("[TB] FAIL fwd_memwb: got %h expected 22", alu_src1_o);
      else pass_cnt++;
      @(negedge clk_i);
      idle_inputs();
      drive_instr(ALU_OR, 5'd0, 5'd0, 5'd4, 32'h44, 32'h55, 1'b0, 1'b0);
      clock_cycle();
      idle_inputs();
      exmem_reg_write_i = 1; exmem_rd_i = 5'd0; exmem_result_i = 32'h11;
      memwb_reg_write_i = 1; memwb_rd_i = 5'd0; memwb_data_i = 32'h22;
      #1;
      chk_cnt++;
      if (alu_src1_o !== 32'h44 || ex_store_data_o !== 32'h55)
         $display("[TB] FAIL fwd_r0: src1=%h store=%h expected 44 55", alu_src1_o, ex_store_data_o);
      else pass_cnt++;
      @(negedge clk_i);
      idle_inputs();
   endtask

   task automatic test_load_use();
      int cnt_before;
      drive_instr(ALU_ADD, 5'd1, 5'd0, 5'd9, 32'd0, 32'd0, 1'b1, 1'b1);
      clock_cycle();
      drive_instr(ALU_ADD, 5'd9, 5'd2, 5'd11, 32'd1, 32'd2, 1'b0, 1'b0);
      #1;
      chk_cnt++;
      if (stall_o !== 1'b1) $display("[TB] FAIL load_use_stall: got %0b expected 1", stall_o);
      else pass_cnt++;
      cnt_before = m_cnt;
      clock_cycle();
      chk_cnt++;
      if (ex_valid_o !== 1'b0 || ex_reg_write_o !== 1'b0 || bubble_cnt_o !== 4'(cnt_before + 1))
         $display("[TB] FAIL load_use_bubble: valid=%0b rw=%0b cnt=%0d expected 0 0 %0d",
                  ex_valid_o, ex_reg_write_o, bubble_cnt_o, cnt_before + 1);
      else pass_cnt++;
      chk_cnt++;
      if (stall_o !== 1'b0) $display("[TB] FAIL load_use_one_cycle: got %0b expected 0", stall_o);
      else pass_cnt++;
      clock_cycle();
      chk_cnt++;
      if (ex_valid_o !== 1'b1 || ex_rd_o !== 5'd11) $display("[TB] FAIL load_use_resume: valid=%0b rd=%0d expected 1 11", ex_valid_o, ex_rd_o);
      else pass_cnt++;
      drive_instr(ALU_ADD, 5'd1, 5'd0, 5'd9, 32'd0, 32'd0, 1'b1, 1'b1);
      clock_cycle();
      drive_instr(ALU_ADD, 5'd3, 5'd9, 5'd12, 32'd1, 32'd2, 1'b1, 1'b0);
      #1;
      chk_cnt++;
      if (stall_o !== 1'b0) $display("[TB] FAIL addi_no_stall: got %0b expected 0", stall_o);
      else pass_cnt++;
      @(negedge clk_i);
      idle_inputs();
   endtask

   task automatic test_flush_load_use();
      int cnt_before;
      drive_instr(ALU_ADD, 5'd1, 5'd0, 5'd9, 32'd0, 32'd0, 1'b1, 1'b1);
      clock_cycle();
      drive_instr(ALU_ADD, 5'd9, 5'd2, 5'd11, 32'd1, 32'd2, 1'b0, 1'b0);
      flush_i = 1;
      #1;
      chk_cnt++;
      if (stall_o !== 1'b0) $display("[TB] FAIL flush_stall: got %0b expected 0", stall_o);
      else pass_cnt++;
      cnt_before = m_cnt;
      clock_cycle();
      chk_cnt++;
      if (ex_valid_o !== 1'b0 || bubble_cnt_o !== 4'(cnt_before + 1))
         $display("[TB] FAIL flush_bubble: valid=%0b cnt=%0d expected 0 %0d", ex_valid_o, bubble_cnt_o, cnt_before + 1);
      else pass_cnt++;
      idle_inputs();
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 18; i++) begin
         drive_instr(ALU_ADD, 5'd1, 5'd0, 5'd9, 32'd0, 32'd0, 1'b1, 1'b1);
         clock_cycle();
         drive_instr(ALU_ADD, 5'd9, 5'd2, 5'd11, 32'd1, 32'd2, 1'b0, 1'b0);
         clock_cycle();
      end
      chk_cnt++;
      if (bubble_cnt_o !== 4'd15 || m_cnt != 15)
         $display("[TB] FAIL saturation: got %0d expected 15", bubble_cnt_o);
      else pass_cnt++;
      idle_inputs();
   endtask

   task automatic test_random();
      int errs;
      errs = 0;
      for (int i = 0; i < 400; i++) begin
         id_valid_i = ($urandom_range(0, 7) != 0);
         id_rs_data_i = $urandom; id_rt_data_i = $urandom; id_imm_i = $urandom;
         id_rs_addr_i = AW'($urandom_range(0, 3)); id_rt_addr_i = AW'($urandom_range(0, 3));
         id_rd_addr_i = AW'($urandom_range(0, 3)); id_alu_ctrl_i = 4'($urandom);
         id_alu_src_i = 1'($urandom); id_reg_write_i = 1'($urandom);
         id_mem_read_i = ($urandom_range(0, 2) == 0); id_mem_write_i = ($urandom_range(0, 3) == 0);
         id_mem_to_reg_i = 1'($urandom); flush_i = ($urandom_range(0, 7) == 0);
         exmem_reg_write_i = 1'($urandom); exmem_rd_i = AW'($urandom_range(0, 3)); exmem_result_i = $urandom;
         memwb_reg_write_i = 1'($urandom); memwb_rd_i = AW'($urandom_range(0, 3)); memwb_data_i = $urandom;
         #1;
         chk_cnt++;
         if (stall_o !== model_stall() || alu_src1_o !== exp_src1() || ex_store_data_o !== exp_store() ||
             (m.valid && alu_src2_o !== exp_src2())) begin
            errs++;
            if (errs < 10)
               $display("[TB] FAIL rand_comb[%0d]: stall=%0b src1=%h src2=%h st=%h expected %0b %h %h %h",
                        i, stall_o, alu_src1_o, alu_src2_o, ex_store_data_o, model_stall(), exp_src1(), exp_src2(), exp_store());
         end else pass_cnt++;
         clock_cycle();
         chk_cnt++;
         if (ex_valid_o !== m.valid || alu_ctrl_o !== m.ctrl || ex_reg_write_o !== m.rw ||
             ex_mem_read_o !== m.mr || ex_mem_write_o !== m.mw || ex_mem_to_reg_o !== m.m2r ||
             (m.valid && ex_rd_o !== m.rd) || bubble_cnt_o !== 4'(m_cnt)) begin
            errs++;
            if (errs < 10)
               $display("[TB] FAIL rand_reg[%0d]: v=%0b ctrl=%b rd=%0d cnt=%0d expected %0b %b %0d %0d",
                        i, ex_valid_o, alu_ctrl_o, ex_rd_o, bubble_cnt_o, m.valid, m.ctrl, m.rd, m_cnt);
         end else pass_cnt++;
      end
      idle_inputs();
   endtask

   // Run each scenario in sequence and report a single summary.
   initial begin
      rst_i = 0;
      idle_inputs();
      m = '0;
      m_cnt = 0;
      #12;
      test_reset();
      test_pass_through();
      test_forwarding();
      test_load_use();
      test_flush_load_use();
      test_random();
      test_saturation();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
